lifo_fifo_core: RTL and testbench
=================================

# lifo_fifo_core

Storage stage directly downstream of the mode-configuration block. Consumes the registered 2-bit `mode` plus push/pop requests and stores data as a single-word buffer, a LIFO stack, or a FIFO queue. Provides registered read data, occupancy, full/empty status and an error pulse for rejected requests. A change of mode flushes the storage.

## Interface
- `DATA_W`, 8, data word width.
- `DEPTH`, 8, storage words; power of 2, ≥ 2.
- `CNT_W`, $clog2(DEPTH+1), occupancy width (derived, not overridden).

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  2  0 BUFFER, 1 LIFO, 2 FIFO, 3 INVALID; driven by the configuration stage.
- `push`  in  1  write request.
- `pop`  in  1  read request.
- `data_in`  in  DATA_W  write data.
- `data_out`  out  DATA_W  registered read data; holds its value until the next accepted read or BUFFER load.
- `out_valid`  out  1  one-cycle pulse when `data_out` was updated this edge.
- `count`  out  CNT_W  words stored.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `err`  out  1  one-cycle pulse on a rejected request.

## Operation
- Operation code `op = {pop, push}`: 0 NIMIC, 1 PUSH, 2 POP, 3 PUSH_POP.
- `mode_q` registers `mode` every cycle. If `mode != mode_q`, the cycle is a flush:
  - pointers and `count` go to 0.
  - `op` is ignored; `err` = 0 and `out_valid` = 0.
  - `data_out` is held.
- **BUFFER**
  - PUSH or PUSH_POP: `data_out <= data_in`, `out_valid` = 1.
  - POP: ignored.
  - Storage is unused, `count` stays 0, `err` is never set.
- **FIFO** (circular `wr_ptr`/`rd_ptr`, wrap from DEPTH-1 to 0)
  - PUSH: when not full, write at `wr_ptr` and `count+1`; when full, reject with `err`.
  - POP: when not empty, `data_out <= mem[rd_ptr]`, `count-1`; when empty, reject with `err`.
  - PUSH_POP when not empty: both requests are accepted and `count` is unchanged. This includes the full case.
  - PUSH_POP when empty: the push is accepted, the pop is dropped silently, and `err` = 0.
- **LIFO** (stack pointer `sp` = `count`)
  - PUSH: write `mem[sp]`.
  - POP: `data_out <= mem[sp-1]`.
  - Full and empty rejections are the same as FIFO.
  - PUSH_POP when not empty: `data_out <= mem[sp-1]`, then `mem[sp-1] <= data_in`; `count` is unchanged.
  - PUSH_POP when empty: push only.
- **INVALID**
  - No state change.
  - `err` = 1 for any op ≠ NIMIC.

## Timing
- Reset values:
  - `data_out` = 0, `out_valid` = 0, `count` = 0, `full` = 0, `empty` = 1, `err` = 0.
  - `mode_q` = 3 and all pointers = 0.
  - Memory contents are not reset.
- Latency:
  - Read data appears on `data_out` 1 cycle after the pop is sampled.
  - A pushed word can be popped from the next cycle.
- Flags (`count`/`full`/`empty`):
  - Registered, and reflect the post-edge state.
  - `full`/`empty` are decoded from the registered `count`.
- The first cycle after reset with `mode` ≠ 3 is a flush cycle.
- Reset asserted mid-operation clears all state immediately, independent of `clk`.
- No ready/backpressure handshake. The requester must observe `full`/`empty`; violating requests are dropped and flagged with `err`.

## Configuration
- Macro `LFC_ALMOST_FLAGS_EN`.
- Defined: adds two registered outputs, reset value 0 and 1 respectively:
  - `almost_full` (1 bit) = `count >= DEPTH-1`.
  - `almost_empty` (1 bit) = `count <= 1`.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

## Test plan
- Reset, then FIFO mode: push 0x11, 0x22, 0x33, then pop ×3 → `data_out` 0x11, 0x22, 0x33 on successive cycles, each with `out_valid`; then `empty` = 1 and `count` = 0.
- LIFO mode: push 0xA0..0xA7 (8 words) → `full` = 1. A 9th push gives `err` pulse and `count` stays 8. Then pop ×8 → `data_out` 0xA7 down to 0xA0, then `empty` = 1. A further pop → `err`.
- FIFO full with 0..7: PUSH_POP with 0x99 → `data_out` = 0 and `count` = 8. Pop ×8 → 1..7 then 0x99; covers pointer wrap.
- LIFO holding 0x05, 0x06: PUSH_POP with 0x07 → `data_out` = 0x06 and `count` = 2. Next pop → 0x07.
- FIFO holding 3 words, switch `mode` to LIFO → flush cycle: `count` = 0, `empty` = 1, push ignored, no `err`. INVALID mode with a push → `err` = 1 and no state change.
- BUFFER mode: push 0x5A → `data_out` = 0x5A next cycle with `out_valid`. A pop alone → no change and no `err`.

Source files
------------

// File: rtl/lifo_fifo_core.sv
// Single-word buffer / LIFO stack / FIFO queue selected by a registered 2-bit mode.
// Optional almost_full/almost_empty outputs are enabled by defining LFC_ALMOST_FLAGS_EN.
module lifo_fifo_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_in_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              out_valid_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o,
`ifdef LFC_ALMOST_FLAGS_EN
  output logic              almost_full_o,
  output logic              almost_empty_o,
`endif
  output logic              err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {ModeBuffer, ModeLifo, ModeFifo, ModeInvalid} mode_e;
  typedef enum logic [1:0] {OpNone, OpPush, OpPop, OpPushPop} op_e;

  mode_e             mode_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;

  op_e              op;
  logic             flush;
  logic             is_full, is_empty;
  logic [PTR_W-1:0] sp_top, sp_wr;

  assign op       = op_e'({pop_i, push_i});
  assign flush    = (mode_i != mode_q);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign is_empty = (count_q == '0);
  // Stack pointer equals count; sp_wr is only used when not full, so truncation is safe.
  assign sp_top   = PTR_W'(count_q - CNT_W'(1));
  assign sp_wr    = PTR_W'(count_q);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      unique case (mode_q)
        ModeBuffer: begin
          if (push_i) begin
            data_out_d  = data_in_i;
            out_valid_d = 1'b1;
          end
        end
        ModeFifo: begin
          unique case (op)
            OpNone: ;
            OpPush: begin
              if (is_full) begin
                err_d = 1'b1;
              end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                count_d  = count_q + CNT_W'(1);
              end
            end
            OpPop: begin
              if (is_empty) begin
                err_d = 1'b1;
              end else begin
                data_out_d  = mem_q[rd_ptr_q];
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                count_d     = count_q - CNT_W'(1);
              end
            end
            OpPushPop: begin
              // When full, wr_ptr == rd_ptr: the read sees the old word before the write lands.
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_W'(1);
              if (is_empty) begin
                count_d = count_q + CNT_W'(1);
              end else begin
                data_out_d  = mem_q[rd_ptr_q];
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + PTR_W'(1);
              end
            end
          endcase
        end
        ModeLifo: begin
          unique case (op)
            OpNone: ;
            OpPush: begin
              if (is_full) begin
                err_d = 1'b1;
              end else begin
                mem_we    = 1'b1;
                mem_waddr = sp_wr;
                count_d   = count_q + CNT_W'(1);
              end
            end
            OpPop: begin
              if (is_empty) begin
                err_d = 1'b1;
              end else begin
                data_out_d  = mem_q[sp_top];
                out_valid_d = 1'b1;
                count_d     = count_q - CNT_W'(1);
              end
            end
            OpPushPop: begin
              mem_we = 1'b1;
              if (is_empty) begin
                mem_waddr = sp_wr;
                count_d   = count_q + CNT_W'(1);
              end else begin
                mem_waddr   = sp_top;
                data_out_d  = mem_q[sp_top];
                out_valid_d = 1'b1;
              end
            end
          endcase
        end
        ModeInvalid: begin
          err_d = (op != OpNone);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= ModeInvalid;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mode_q      <= mode_e'(mode_i);
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= data_in_i;
    end
  end

  assign data_out_o  = data_out_q;
  assign out_valid_o = out_valid_q;
  assign count_o     = count_q;
  assign full_o      = is_full;
  assign empty_o     = is_empty;
  assign err_o       = err_q;

`ifdef LFC_ALMOST_FLAGS_EN
  assign almost_full_o  = (count_q >= CNT_W'(DEPTH - 1));
  assign almost_empty_o = (count_q <= CNT_W'(1));
`endif

endmodule

// File: tb/tb_lifo_fifo_core.sv
// Scoreboard bench for lifo_fifo_core: expected read data queued at pop time, compared on out_valid.
module tb_lifo_fifo_core;

  localparam logic [1:0] MBUF = 2'd0;
  localparam logic [1:0] MLIFO = 2'd1;
  localparam logic [1:0] MFIFO = 2'd2;
  localparam logic [1:0] MINV = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       push, pop;
  logic [7:0] din;
  logic [7:0] dout;
  logic       out_valid, full, empty, err;
  logic [3:0] count;
`ifdef LFC_ALMOST_FLAGS_EN
  logic       almost_full, almost_empty;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  lifo_fifo_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_i      (mode),
    .push_i      (push),
    .pop_i       (pop),
    .data_in_i   (din),
    .data_out_o  (dout),
    .out_valid_o (out_valid),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty),
`ifdef LFC_ALMOST_FLAGS_EN
    .almost_full_o  (almost_full),
    .almost_empty_o (almost_empty),
`endif
    .err_o       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given request; outputs sampled 1 time unit after the edge.
  task automatic drive(input logic [1:0] m, input logic ph, input logic pp, input logic [7:0] d,
                       input logic exp_vld, input logic exp_err);
    logic [7:0] exp_data;
    mode = m;
    push = ph;
    pop  = pp;
    din  = d;
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(exp_vld));
    check("err", 32'(err), 32'(exp_err));
    if (out_valid) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_data = sb.pop_front();
        check("data_out", 32'(dout), 32'(exp_data));
      end
    end
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic flags(input string tag, input int exp_cnt);
    check({tag, "_count"}, 32'(count), 32'(exp_cnt));
    check({tag, "_full"}, 32'(full), 32'(exp_cnt == 8));
    check({tag, "_empty"}, 32'(empty), 32'(exp_cnt == 0));
  endtask

  initial begin
    rst_n = 1'b0;
    mode  = MINV;
    push  = 1'b0;
    pop   = 1'b0;
    din   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_data_out", 32'(dout), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    flags("rst", 0);

    // FIFO ordering
    drive(MFIFO, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    flags("fifo_flush", 0);
    drive(MFIFO, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    drive(MFIFO, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
    drive(MFIFO, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    flags("fifo3", 3);
    sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
    for (int i = 0; i < 3; i++) drive(MFIFO, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    flags("fifo_drained", 0);

    // FIFO full push_pop with pointer wrap (pointers start at 3)
    for (int i = 0; i < 8; i++) drive(MFIFO, 1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    flags("fifo_full", 8);
    drive(MFIFO, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b1);
    flags("fifo_full_rej", 8);
    sb.push_back(8'h00);
    drive(MFIFO, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
    flags("fifo_pp_full", 8);
    for (int i = 1; i < 8; i++) sb.push_back(8'(i));
    sb.push_back(8'h99);
    for (int i = 0; i < 8; i++) drive(MFIFO, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    flags("fifo_wrap_drained", 0);
    drive(MFIFO, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

    // LIFO fill, overflow, drain, underflow
    drive(MLIFO, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    flags("lifo_flush", 0);
    for (int i = 0; i < 8; i++) drive(MLIFO, 1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0, 1'b0);
    flags("lifo_full", 8);
    drive(MLIFO, 1'b1, 1'b0, 8'hA8, 1'b0, 1'b1);
    flags("lifo_full_rej", 8);
    for (int i = 7; i >= 0; i--) sb.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 8; i++) drive(MLIFO, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    flags("lifo_drained", 0);
    drive(MLIFO, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

    // LIFO push_pop swaps the top
    drive(MLIFO, 1'b1, 1'b0, 8'h05, 1'b0, 1'b0);
    drive(MLIFO, 1'b1, 1'b0, 8'h06, 1'b0, 1'b0);
    sb.push_back(8'h06);
    drive(MLIFO, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0);
    flags("lifo_pp", 2);
    sb.push_back(8'h07);
    drive(MLIFO, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    flags("lifo_pp_pop", 1);

    // FIFO push_pop on empty, then mode change flush ignoring a push
    drive(MFIFO, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    flags("fifo2_flush", 0);
    drive(MFIFO, 1'b1, 1'b1, 8'h31, 1'b0, 1'b0);
    flags("fifo_pp_empty", 1);
    drive(MFIFO, 1'b1, 1'b0, 8'h32, 1'b0, 1'b0);
    drive(MFIFO, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    flags("fifo2_3", 3);
    drive(MLIFO, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    flags("switch_flush", 0);
    drive(MLIFO, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    check("flush_hold_dout", 32'(dout), 32'h07);

    // INVALID mode
    drive(MINV, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(MINV, 1'b1, 1'b0, 8'h44, 1'b0, 1'b1);
    flags("invalid", 0);
    check("invalid_dout", 32'(dout), 32'h07);

    // BUFFER mode
    drive(MBUF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    sb.push_back(8'h5A);
    drive(MBUF, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0);
    drive(MBUF, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check("buf_hold", 32'(dout), 32'h5A);
    flags("buf", 0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset away from the clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dout", 32'(dout), 32'h0);
    flags("async_rst", 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
